// File: rtl/latency_memory.sv
// latency_memory: word-addressed memory behind a valid/ready request handshake.
// Each access is accepted in IDLE and spends LATENCY cycles in BUSY.
// The array is read or written on the edge that enters RESP.
// RESP then drives a one-cycle completion pulse.
module latency_memory #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 4,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_input_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  output logic        is_ready,
  output logic        is_output_valid,
  output logic [31:0] dout
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } state_e;

  state_e          r_state;
  state_e          w_state_next;
  logic [CntW-1:0] r_cnt;
  logic            r_is_write;
  logic [IdxW-1:0] r_idx;
  logic [31:0]     r_din;
  logic [31:0]     r_dout;
  logic [31:0]     r_mem [DEPTH_WORDS];

  logic w_legal_req;
  logic w_accept;
  logic w_done;
  logic w_unused_addr;

  // Exactly one of read/write must be requested; anything else is ignored.
  assign w_legal_req = is_input_valid & (mem_read ^ mem_write);
  assign w_accept    = (r_state == StIdle) & w_legal_req;
  // Last BUSY cycle: the array access happens on the edge that ends it.
  assign w_done      = (r_state == StBusy) & (r_cnt == '0);

  // Byte-lane bits and bits above the index are dropped, so addresses wrap.
  assign w_unused_addr = ^{addr[31:IdxW+2], addr[1:0]};

  assign dout = r_dout;

  // Next-state and handshake outputs, decoded from the current state.
  always_comb begin
    w_state_next    = r_state;
    is_ready        = 1'b0;
    is_output_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        is_ready = 1'b1;
        if (w_legal_req) begin
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        if (r_cnt == '0) begin
          w_state_next = StResp;
        end
      end
      StResp: begin
        is_output_valid = 1'b1;
        w_state_next    = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Request capture, latency countdown and read-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt      <= '0;
      r_is_write <= 1'b0;
      r_idx      <= '0;
      r_din      <= '0;
      r_dout     <= '0;
    end else begin
      if (w_accept) begin
        r_cnt      <= CntInit;
        r_is_write <= mem_write;
        r_idx      <= addr[IdxW+1:2];
        r_din      <= din;
      end else if ((r_state == StBusy) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done && !r_is_write) begin
        r_dout <= r_mem[r_idx];
      end
    end
  end

  // Array write port; no reset so contents survive a reset, and a reset
  // during BUSY returns the FSM to IDLE before the commit edge.
  always_ff @(posedge clk) begin
    if (w_done && r_is_write) begin
      r_mem[r_idx] <= r_din;
    end
  end

endmodule

// File: tb/tb_latency_memory.sv
// Scoreboard bench for latency_memory: a driver issues requests and queues
// expected completions from a word-array reference model; a monitor pops
// and compares on every completion pulse.
module tb_latency_memory;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 4;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv, rd, wr;
  logic [31:0] addr, din;
  logic        rdy, ov;
  logic [31:0] dout;

  logic        iv1, rd1, wr1;
  logic [31:0] addr1, din1;
  logic        rdy1, ov1;
  logic [31:0] dout1;

  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  exp_t        q[$];
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  // Edge counter: at a negedge it equals the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  latency_memory #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .is_input_valid (iv),
    .mem_read       (rd),
    .mem_write      (wr),
    .addr           (addr),
    .din            (din),
    .is_ready       (rdy),
    .is_output_valid(ov),
    .dout           (dout)
  );

  latency_memory #(
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (1)
  ) u_dut1 (
    .clk            (clk),
    .reset          (reset),
    .is_input_valid (iv1),
    .mem_read       (rd1),
    .mem_write      (wr1),
    .addr           (addr1),
    .din            (din1),
    .is_ready       (rdy1),
    .is_output_valid(ov1),
    .dout           (dout1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Word index: byte address divided by four, wrapped to the array size.
  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Monitor: every completion pulse must match the oldest outstanding request.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset && ov) begin
      if (q.size() == 0) begin
        check("spurious_valid", {31'b0, ov}, 32'd0);
      end else begin
        e = q.pop_front();
        check("resp_latency", cyc, e.acc + LAT);
        check("ready_in_resp", {31'b0, rdy}, 32'd0);
        if (e.rd) check("read_data", dout, e.data);
      end
    end
  end

  // Issue one request on the main DUT once it is ready; legal requests are
  // queued with their expected result and the model is updated in order.
  task automatic req0(input bit r, input bit w, input logic [31:0] a,
                      input logic [31:0] d, output int acc);
    int   t = 0;
    exp_t e;
    acc = -1;
    @(negedge clk);
    while (!rdy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!rdy) begin
      check("ready_timeout", {31'b0, rdy}, 32'd1);
      return;
    end
    iv = 1'b1; rd = r; wr = w; addr = a; din = d;
    if (r ^ w) begin
      acc   = cyc + 1;
      e.rd  = r;
      e.acc = acc;
      if (r) begin
        e.data = model[widx(a)];
      end else begin
        e.data = d;
        model[widx(a)] = d;
      end
      q.push_back(e);
    end
    @(negedge clk);
    // Scramble inputs after acceptance: the DUT must have latched them.
    iv = 1'b0; rd = 1'($urandom); wr = 1'($urandom); addr = $urandom; din = $urandom;
    if (!(r ^ w)) check("illegal_ignored", {31'b0, rdy}, 32'd1);
  endtask

  task automatic drain();
    int t = 0;
    while ((q.size() != 0 || !rdy) && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("drain", {31'b0, (q.size() == 0)}, 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: run did not end, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stim
    int          acc, acc2, t;
    int          acc1;
    logic [31:0] a1 [3];
    logic [31:0] d1 [3];

    reset = 1'b1;
    iv = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; din = '0;
    iv1 = 1'b0; rd1 = 1'b0; wr1 = 1'b0; addr1 = '0; din1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_ready", {31'b0, rdy}, 32'd1);
    check("reset_valid", {31'b0, ov}, 32'd0);
    check("reset_dout", dout, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", {31'b0, rdy}, 32'd1);
      check("idle_valid", {31'b0, ov}, 32'd0);
    end

    // Give every word a known value so later reads have a defined answer.
    for (int i = 0; i < DEPTH; i++) req0(1'b0, 1'b1, 32'(i * 4), $urandom, acc);
    drain();

    // Write then read the same word; back-to-back issue interval.
    req0(1'b0, 1'b1, 32'h40, 32'hDEADBEEF, acc);
    req0(1'b1, 1'b0, 32'h40, 32'h0, acc2);
    check("issue_interval", 32'(acc2 - acc), LAT + 2);
    drain();

    // Wrap above the index and truncate misaligned bytes.
    req0(1'b0, 1'b1, 32'h404, 32'h11, acc);
    req0(1'b1, 1'b0, 32'h006, 32'h0, acc);
    drain();

    // Both and neither op bits: never accepted, array untouched.
    @(negedge clk);
    iv = 1'b1; rd = 1'b1; wr = 1'b1; addr = 32'h40; din = 32'h12345678;
    repeat (3) begin
      @(negedge clk);
      check("both_ready", {31'b0, rdy}, 32'd1);
      check("both_valid", {31'b0, ov}, 32'd0);
    end
    rd = 1'b0; wr = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("neither_ready", {31'b0, rdy}, 32'd1);
    end
    iv = 1'b0;
    req0(1'b1, 1'b0, 32'h40, 32'h0, acc);
    drain();

    // Reset during BUSY aborts a write without committing it.
    @(negedge clk);
    iv = 1'b1; rd = 1'b0; wr = 1'b1; addr = 32'h80; din = 32'h55;
    @(negedge clk);
    iv = 1'b0; wr = 1'b0;
    check("abort_busy", {31'b0, rdy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_ready", {31'b0, rdy}, 32'd1);
    check("abort_valid", {31'b0, ov}, 32'd0);
    check("abort_dout", dout, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    req0(1'b1, 1'b0, 32'h80, 32'h0, acc);
    drain();

    // Reset during RESP drops the completion pulse at once.
    req0(1'b1, 1'b0, 32'h100, 32'h0, acc);
    t = 0;
    while (!ov && t < 20) begin
      @(negedge clk);
      t++;
    end
    #2;
    reset = 1'b1;
    #1;
    check("abort_resp_valid", {31'b0, ov}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drain();

    // Randomised traffic, including occasional illegal requests.
    for (int i = 0; i < 60; i++) begin
      bit r, w;
      int k;
      k = $urandom_range(0, 7);
      if (k == 0) begin
        r = 1'b1; w = 1'b1;
      end else if (k == 1) begin
        r = 1'b0; w = 1'b0;
      end else begin
        r = 1'($urandom); w = !r;
      end
      req0(r, w, $urandom, $urandom, acc);
    end
    drain();

    // LATENCY=1 instance: held-valid reads at the minimum issue interval.
    a1[0] = 32'h10; a1[1] = 32'h24; a1[2] = 32'h3FC;
    for (int k = 0; k < 3; k++) begin
      d1[k] = $urandom;
      @(negedge clk);
      t = 0;
      while (!rdy1 && t < 10) begin
        @(negedge clk);
        t++;
      end
      iv1 = 1'b1; wr1 = 1'b1; rd1 = 1'b0; addr1 = a1[k]; din1 = d1[k];
      @(negedge clk);
      iv1 = 1'b0; wr1 = 1'b0;
    end
    @(negedge clk);
    t = 0;
    while (!rdy1 && t < 10) begin
      @(negedge clk);
      t++;
    end
    iv1 = 1'b1; rd1 = 1'b1; wr1 = 1'b0; addr1 = a1[0];
    acc1 = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      t = 0;
      while (!ov1 && t < 10) begin
        @(negedge clk);
        t++;
      end
      check("l1_valid_time", cyc, acc1 + 1 + 3 * k);
      check("l1_read_data", dout1, d1[k]);
      if (k < 2) addr1 = a1[k + 1];
      else iv1 = 1'b0;
      @(negedge clk);
      check("l1_pulse_width", {31'b0, ov1}, 32'd0);
    end
    iv1 = 1'b0; rd1 = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
